// File: rtl/byte_assembler.sv
// Serial-to-byte assembler: writes strobed bits into a byte register at the FSM's
// bit index and queues each completed byte into a small valid/ready FIFO.
module byte_assembler #(
  parameter int DEPTH = 2,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          strobe,
  input  logic          active,
  input  logic [2:0]    bitno,
  input  logic          din,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] level,
  output logic          overrun,
  input  logic          overrun_clr
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]            shreg;
  logic [DEPTH-1:0][7:0] mem;
  logic [PW-1:0]         wptr, rptr, rptr_n;
  logic [LW-1:0]         level_n;
  logic [7:0]            byte_in, head_n;
  logic                  samp, push, pop, accept;

  always_comb begin
    samp    = strobe & active;
    push    = samp & (bitno == 3'd7);
    byte_in = {din, shreg[6:0]};
    pop     = out_valid & out_ready;
    accept  = push & ((level < LW'(DEPTH)) | pop);
    rptr_n  = pop ? rptr + PW'(1) : rptr;
    level_n = level;
    if (accept & ~pop)      level_n = level + LW'(1);
    else if (~accept & pop) level_n = level - LW'(1);
    // A byte pushed into a FIFO that is empty after this cycle's pop becomes the head
    // directly, since it is not yet readable from mem.
    head_n = (accept && level_n == LW'(1)) ? byte_in : mem[rptr_n];
  end

  always_ff @(posedge sys_clk) begin
    if (accept) mem[wptr] <= byte_in;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      shreg     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (samp)   shreg[bitno] <= din;
      if (accept) wptr <= wptr + PW'(1);
      rptr      <= rptr_n;
      level     <= level_n;
      out_valid <= (level_n != '0);
      out_data  <= head_n;
      if (push & ~accept)   overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_byte_assembler.sv
// Scoreboard bench for byte_assembler: stimulus queues expected bytes, a negedge
// monitor pops and compares them whenever the DUT hands a byte over.
module tb_byte_assembler;

  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n, strobe, active, din, out_ready, overrun_clr;
  logic [2:0]    bitno;
  logic [7:0]    out_data;
  logic          out_valid, overrun;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  byte_assembler #(.DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .strobe(strobe), .active(active),
    .bitno(bitno), .din(din), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 sys_clk = ~sys_clk;

  // Monitor: a handshake visible at negedge completes at the next posedge.
  always @(negedge sys_clk) begin
    if (sys_rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %02h, no byte expected", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL pop_data: got %02h, expected %02h", out_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_bit(input logic [2:0] b, input logic d, input logic act);
    strobe = 1'b1; active = act; bitno = b; din = d;
    tick();
    strobe = 1'b0; active = 1'b0; din = 1'b0; bitno = 3'd0;
  endtask

  // Start strobe (bitno 0, din 1) then bits 0..6 LSB-first.
  task automatic send_pre(input logic [7:0] v);
    send_bit(3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) send_bit(3'(i), v[i], 1'b1);
  endtask

  task automatic send_last(input logic [7:0] v, input bit expect_push);
    if (expect_push) exp_q.push_back(v);
    send_bit(3'd7, v[7], 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit expect_push);
    send_pre(v);
    send_last(v, expect_push);
  endtask

  initial begin
    sys_rst_n = 1'b0; strobe = 1'b0; active = 1'b0; bitno = 3'd0; din = 1'b0;
    out_ready = 1'b1; overrun_clr = 1'b0;
    tick(); tick();
    sys_rst_n = 1'b1;
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_overrun", 32'(overrun), 0);

    // Single byte with one-cycle latency
    send_pre(8'hA5);
    chk("a5_valid_before", 32'(out_valid), 0);
    send_last(8'hA5, 1'b1);
    chk("a5_valid_after", 32'(out_valid), 1);
    chk("a5_level_after", 32'(level), 1);
    tick();
    chk("a5_level_drained", 32'(level), 0);
    chk("a5_overrun", 32'(overrun), 0);

    // Backpressure: third byte dropped
    out_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    chk("bp_level", 32'(level), 2);
    chk("bp_overrun", 32'(overrun), 1);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("bp_level_drained", 32'(level), 0);

    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("clr_overrun", 32'(overrun), 0);

    // Full with simultaneous push and pop
    out_ready = 1'b0;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_pre(8'h03);
    out_ready = 1'b1;
    send_last(8'h03, 1'b1);
    out_ready = 1'b0;
    chk("pp_level", 32'(level), 2);
    chk("pp_overrun", 32'(overrun), 0);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("pp_level_drained", 32'(level), 0);

    // Overrun set and clear in the same cycle: set wins
    out_ready = 1'b0;
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b0);
    chk("race_overrun_set", 32'(overrun), 1);
    send_pre(8'h77);
    overrun_clr = 1'b1;
    send_last(8'h77, 1'b0);
    chk("race_overrun_held", 32'(overrun), 1);
    tick();
    overrun_clr = 1'b0;
    chk("race_overrun_clr", 32'(overrun), 0);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("race_level_drained", 32'(level), 0);

    // Unqualified strobes ignored; shreg still holds 0x77 in bits 6:0
    for (int i = 0; i < 8; i++) send_bit(3'(i), 1'b1, 1'b0);
    send_bit(3'd7, 1'b1, 1'b0);
    chk("qual_level", 32'(level), 0);
    chk("qual_valid", 32'(out_valid), 0);
    exp_q.push_back(8'h77);
    send_bit(3'd7, 1'b0, 1'b1);
    chk("qual_push_valid", 32'(out_valid), 1);
    tick();

    // Reset mid-byte with one byte queued
    out_ready = 1'b0;
    send_byte(8'h5A, 1'b0);
    send_bit(3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(3'(i), 1'b1, 1'b1);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    chk("mrst_level", 32'(level), 0);
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_data", 32'(out_data), 0);
    chk("mrst_overrun", 32'(overrun), 0);
    out_ready = 1'b1;
    exp_q.push_back(8'h80);
    send_bit(3'd7, 1'b1, 1'b1);
    tick();
    send_byte(8'h3C, 1'b1);
    tick(); tick();
    chk("final_level", 32'(level), 0);
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_assembler.md
# byte_assembler

Downstream companion to the bit-counting strobe FSM. Samples a serial data bit on every qualified strobe and writes it into a byte register at the index given by the FSM's `bitno`. On bit 7 it pushes the finished byte into a small FIFO, which drains over a valid/ready handshake. Sits between the strobe/bit-count FSM and any byte-wide consumer (register file, host FIFO).

## Interface
Parameters:
- `DEPTH`, 2: FIFO depth in bytes; power of two, ≥2.
- `LW`, $clog2(DEPTH)+1: width of `level`; derived, not overridden.

Ports:
- `sys_clk`  in  1  sole clock; all logic on rising edge.
- `sys_rst_n`  in  1  reset; synchronous, active-low.
- `strobe`  in  1  bit strobe, same signal that drives the FSM.
- `active`  in  1  FSM `active` output; qualifies `strobe`.
- `bitno`  in  3  FSM bit index, sampled the same cycle as `strobe`.
- `din`  in  1  serial data bit, valid when `strobe` is high.
- `out_data`  out  8  FIFO head byte.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head when high with `out_valid`.
- `level`  out  LW  FIFO occupancy, 0..DEPTH.
- `overrun`  out  1  sticky; a completed byte was dropped.
- `overrun_clr`  in  1  clears `overrun`.

## Operation
- Sample: `samp = strobe & active`. On `samp`, `shreg[bitno] <= din`; other bits hold. Repeated writes to one index: last write wins. This covers the FSM's start strobe, which arrives with `bitno`=0 before the real bit 0.
- Complete: `push = samp & (bitno == 7)`. The pushed byte is `{din, shreg[6:0]}`, so the current bit is included combinationally. `shreg` is not cleared after a push.
- Pop: `pop = out_valid & out_ready`.
- FIFO: circular buffer with read/write pointers, `level` tracked explicitly.
  - Push is accepted when `level < DEPTH` or `pop` is high the same cycle.
  - Push and pop together leave `level` unchanged.
  - `level` never exceeds DEPTH and never underflows.
- Overrun: a push that is not accepted discards its byte and sets `overrun`. FIFO contents are unchanged.
  - `overrun_clr` clears it on the next edge.
  - A new overrun in the same cycle as `overrun_clr` wins; `overrun` stays 1.
- `out_data` is the FIFO head entry. It is held stable while `out_valid & ~out_ready`. It is don't-care when `out_valid`=0; the model reads the stale head, and the bench ignores it.
- `strobe` with `active`=0 is ignored completely, whatever `bitno` and `din` are.
- No internal bit counter and no check of `bitno` sequence; the FSM owns framing.

## Timing
- Reset (`sys_rst_n`=0 at an edge) gives: `shreg`=0, pointers=0, `level`=0, `out_valid`=0, `out_data`=0, `overrun`=0.
  - Reset takes priority over every other input that cycle.
  - Reset mid-byte discards the partial byte and all queued bytes.
- Latency: a `push` at edge k gives `out_valid`=1, `level` incremented and `out_data`=byte after edge k. That is one cycle from the bit-7 strobe to visible data.
- Pop at edge k gives the next entry (or `out_valid`=0) after edge k. Back-to-back pops sustain one byte per cycle.
- Full with push and pop together: both succeed, no overrun, the new byte lands at the tail.
- Empty with push only: `out_valid` rises the next cycle. A pop in that same cycle is impossible because `out_valid`=0.
- No combinational path from `out_ready` to `out_valid` or `out_data`. `level`, `out_valid`, `out_data` and `overrun` are all registered.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Correct ordering across wrap is required.

## Test plan
- Single byte 0xA5: start strobe (`bitno`=0, `din`=1), then 8 strobes at `bitno` 0..7 with `din` LSB-first, `out_ready`=1 → `out_data`=0xA5 with `out_valid` high exactly one cycle after the bit-7 strobe; `level` returns to 0; `overrun`=0.
- Backpressure, `DEPTH`=2, `out_ready`=0: send 0x11, 0x22, 0x33 → `level`=2, `overrun`=1. Then `out_ready`=1 → pops 0x11 then 0x22; 0x33 is never seen.
- Full plus simultaneous push and pop: FIFO holds 0x01, 0x02; bit-7 strobe completing 0x03 in the same cycle as a pop → `level` stays 2, `overrun`=0. Drain order is 0x02, 0x03.
- Overrun clear race: `overrun`=1, FIFO full, assert `overrun_clr` in the same cycle as a dropped push → `overrun` stays 1. `overrun_clr` alone on the next cycle → 0.
- Qualification: strobes with `active`=0 and `din`=1 at `bitno`=7 → no push, `level`=0, `shreg` unchanged.
- Reset mid-operation: 4 bits into a byte, with 1 byte queued, pull `sys_rst_n` low one cycle → all outputs at reset values. A following full byte 0x3C is delivered correctly with no residue from before reset.
